// File: rtl/conv3x3_stream_if.sv
// Signal bundle for conv3x3_stream: pixel stream in, coefficient write port,
// result stream and frame status out.
interface conv3x3_stream_if #(
   parameter int PIX_W  = 9,
   parameter int COEF_W = 9,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
);
   localparam int SUM_W = PIX_W + COEF_W + 5;
   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);

   logic                     start;
   logic [PIX_W-1:0]         pix_in;
   logic                     pix_valid;
   logic                     pix_ready;
   logic                     coef_we;
   logic [3:0]               coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic signed [SUM_W-1:0]  out_sum;
   logic                     out_valid;
   logic [XW-1:0]            out_x;
   logic [YW-1:0]            out_y;
   logic                     busy;
   logic                     done;

   modport master (
      output start, pix_in, pix_valid, coef_we, coef_addr, coef_data,
      input  pix_ready, out_sum, out_valid, out_x, out_y, busy, done
   );

   modport slave (
      input  start, pix_in, pix_valid, coef_we, coef_addr, coef_data,
      output pix_ready, out_sum, out_valid, out_x, out_y, busy, done
   );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two line-deep delay lines feed a 3x3 window that is
// multiplied by a loadable signed kernel, one full-precision sum per interior pixel.
module conv3x3_stream #(
   parameter int PIX_W  = 9,
   parameter int COEF_W = 9,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input logic              clk,
   input logic              reset,
   conv3x3_stream_if.slave  bus
);
   localparam int SUM_W  = PIX_W + COEF_W + 5;
   localparam int PROD_W = PIX_W + COEF_W + 1;
   localparam int XW     = $clog2(IMG_W);
   localparam int YW     = $clog2(IMG_H);
   localparam logic [XW-1:0] LAST_COL = XW'(IMG_W - 1);
   localparam logic [YW-1:0] LAST_ROW = YW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

   state_t                   state_q, state_d;
   logic [XW-1:0]            col_q;
   logic [YW-1:0]            row_q;
   logic signed [COEF_W-1:0] coef_q [9];
   logic [PIX_W-1:0]         line0_q [IMG_W];
   logic [PIX_W-1:0]         line1_q [IMG_W];
   logic [PIX_W-1:0]         win_q [3][2];
   logic [PIX_W-1:0]         tap [3][3];
   logic signed [PROD_W-1:0] prod;
   logic signed [SUM_W-1:0]  sum;
   logic signed [SUM_W-1:0]  outSum_q;
   logic                     outValid_q;
   logic [XW-1:0]            outX_q;
   logic [YW-1:0]            outY_q;
   logic                     transfer;
   logic                     lastPix;
   logic                     winValid;

   assign transfer = bus.pix_valid && (state_q == RUN);
   assign lastPix  = (col_q == LAST_COL) && (row_q == LAST_ROW);
   assign winValid = (col_q >= XW'(2)) && (row_q >= YW'(2));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (transfer && lastPix) state_d = LAST;
         LAST:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Raster position of the pixel about to be accepted; a new frame always starts at (0,0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
      end else if (state_q == IDLE && bus.start) begin
         col_q <= '0;
         row_q <= '0;
      end else if (transfer) begin
         if (col_q == LAST_COL) begin
            col_q <= '0;
            row_q <= lastPix ? '0 : row_q + YW'(1);
         end else begin
            col_q <= col_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 9; i++) coef_q[i] <= '0;
         coef_q[4] <= COEF_W'(1);
      end else if (state_q == IDLE && bus.coef_we && bus.coef_addr < 4'd9) begin
         coef_q[bus.coef_addr] <= bus.coef_data;
      end
   end

   // Buffers carry no reset: border windows never emit, so stale data cannot leak out.
   always_ff @(posedge clk) begin
      if (transfer) begin
         line0_q[0] <= bus.pix_in;
         line1_q[0] <= line0_q[IMG_W-1];
         for (int i = 1; i < IMG_W; i++) begin
            line0_q[i] <= line0_q[i-1];
            line1_q[i] <= line1_q[i-1];
         end
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= tap[r][2];
         end
      end
   end

   // The newest window column comes straight from the line-buffer tails and the incoming
   // pixel, so the sum for the accepted pixel is ready at its own transfer edge.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         tap[r][0] = win_q[r][0];
         tap[r][1] = win_q[r][1];
      end
      tap[0][2] = line1_q[IMG_W-1];
      tap[1][2] = line0_q[IMG_W-1];
      tap[2][2] = bus.pix_in;
   end

   always_comb begin
      sum  = '0;
      prod = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            prod = PROD_W'(signed'({1'b0, tap[r][c]})) * PROD_W'(coef_q[3*r+c]);
            sum  = sum + SUM_W'(prod);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outValid_q <= 1'b0;
         outSum_q   <= '0;
         outX_q     <= '0;
         outY_q     <= '0;
      end else begin
         outValid_q <= transfer && winValid;
         if (transfer && winValid) begin
            outSum_q <= sum;
            outX_q   <= col_q - XW'(1);
            outY_q   <= row_q - YW'(1);
         end
      end
   end

   assign bus.pix_ready = (state_q == RUN);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == LAST);
   assign bus.out_valid = outValid_q;
   assign bus.out_sum   = outSum_q;
   assign bus.out_x     = outX_q;
   assign bus.out_y     = outY_q;
endmodule
